lin_search_engine: RTL and testbench

//   Hardware linear-search accelerator alongside the pipe_MIPS32 core. Holds a

---
 rtl/lin_search_engine.sv | 108 ++++++++++
 tb/tb_lin_search_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lin_search_engine.sv
// Linear-search accelerator: scans the first len entries of a DEPTH x DATA_W table
// for a key, one compare per clock, reporting first-match index and match count.
module lin_search_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] match_idx,
    output logic [ADDR_W:0]   match_cnt
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  tbl [DEPTH];
    logic [DATA_W-1:0]  key_q;
    logic               mode_q;
    logic [CNT_W-1:0]   n_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [CNT_W-1:0]   n_c;
    logic               hit_c;
    logic               last_c;
    logic               stop_c;
    logic               launch_c;

    assign n_c      = (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
    assign hit_c    = (tbl[idx_q] == key_q);
    assign last_c   = ({1'b0, idx_q} == (n_q - CNT_W'(1)));
    assign stop_c   = (!mode_q && hit_c) || last_c;
    assign launch_c = (state_q == IDLE) && start;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (n_c == '0) ? DONE : SCAN;
            SCAN: if (stop_c) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

    // Scan datapath and result registers
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            mode_q    <= 1'b0;
            n_q       <= '0;
            idx_q     <= '0;
            found     <= 1'b0;
            match_idx <= '0;
            match_cnt <= '0;
        end else if (launch_c) begin
            key_q     <= key;
            mode_q    <= mode;
            n_q       <= n_c;
            idx_q     <= '0;
            found     <= 1'b0;
            match_idx <= '0;
            match_cnt <= '0;
        end else if (state_q == SCAN) begin
            if (hit_c) begin
                match_cnt <= match_cnt + CNT_W'(1);
                if (!found) begin
                    found     <= 1'b1;
                    match_idx <= idx_q;
                end
            end
            if (!stop_c) idx_q <= idx_q + ADDR_W'(1);
        end
    end

    // Table storage; writes are locked out while a search is in flight
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (wr_en && (state_q == IDLE)) begin
            tbl[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_lin_search_engine.sv
// Self-checking bench for lin_search_engine against a behavioural search model.
module tb_lin_search_engine;
    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [31:0] key;
    logic        mode;
    logic [4:0]  len;
    logic        busy, done, found;
    logic [3:0]  match_idx;
    logic [4:0]  match_cnt;

    logic [31:0] model_tbl [16];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk1 = ~clk1;

    lin_search_engine dut (
        .clk1(clk1), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .key(key), .mode(mode), .len(len),
        .busy(busy), .done(done), .found(found), .match_idx(match_idx),
        .match_cnt(match_cnt)
    );

    task automatic write_entry(input int a, input logic [31:0] d);
        @(negedge clk1);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        @(posedge clk1); #1;
        wr_en = 1'b0;
        model_tbl[a] = d;
    endtask

    // Behavioural reference: plain loop over the model table
    task automatic model_search(input logic [31:0] k, input logic md, input int ln,
                                output int lat, output logic f, output int fi, output int cnt);
        int n;
        n = (ln > 16) ? 16 : ln;
        f = 1'b0; fi = 0; cnt = 0; lat = 0;
        for (int i = 0; i < n; i++) begin
            lat = i + 1;
            if (model_tbl[i] == k) begin
                if (!f) fi = i;
                f = 1'b1;
                cnt++;
                if (!md) break;
            end
        end
    endtask

    // Launch a search with start already driven; checks latency, busy and results
    task automatic finish_search(input string name, input logic [31:0] k, input logic md,
                                 input int ln, input logic inject);
        int lat, exp_lat, exp_fi, exp_cnt, busy_gaps;
        logic exp_f;
        model_search(k, md, ln, exp_lat, exp_f, exp_fi, exp_cnt);
        @(posedge clk1); #1;
        start = 1'b0;
        lat = 0; busy_gaps = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_gaps++;
            if (inject && lat == 2) begin
                wr_en = 1'b1; wr_addr = 4'd5; wr_data = k; start = 1'b1;
            end
            @(posedge clk1); #1;
            wr_en = 1'b0; start = 1'b0;
            lat++;
        end
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_tests++;
        if (busy !== 1'b1 || busy_gaps != 0) begin
            n_fail++; $display("FAIL %s busy: busy=%b gaps=%0d want busy=1 gaps=0", name, busy, busy_gaps);
        end
        n_tests++;
        if (found !== exp_f || match_idx !== 4'(exp_fi) || match_cnt !== 5'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s result: got f=%b i=%0d c=%0d want f=%b i=%0d c=%0d",
                     name, found, match_idx, match_cnt, exp_f, exp_fi, exp_cnt);
        end
        @(posedge clk1); #1;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || found !== exp_f || match_cnt !== 5'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s after-done: got done=%b busy=%b f=%b c=%0d want 0 0 %b %0d",
                     name, done, busy, found, match_cnt, exp_f, exp_cnt);
        end
    endtask

    task automatic run_search(input string name, input logic [31:0] k, input logic md, input int ln);
        @(negedge clk1);
        start = 1'b1; key = k; mode = md; len = 5'(ln);
        finish_search(name, k, md, ln, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; key = '0; mode = 1'b0; len = '0;
        for (int i = 0; i < 16; i++) model_tbl[i] = '0;
        repeat (2) @(posedge clk1);
        #1; rst_n = 1'b1;
        n_tests++;
        if ({busy, done, found, match_idx, match_cnt} !== 12'd0) begin
            n_fail++; $display("FAIL reset outputs: got %b want 0", {busy, done, found, match_idx, match_cnt});
        end
    endtask

    task automatic test_basic;
        write_entry(0, 1); write_entry(1, 2); write_entry(2, 3);
        run_search("first_match", 32'd1, 1'b0, 3);
        run_search("last_match", 32'd3, 1'b0, 3);
    endtask

    task automatic test_modes;
        int d [8] = '{5, 9, 5, 0, 5, 7, 5, 1};
        for (int i = 0; i < 8; i++) write_entry(i, 32'(d[i]));
        run_search("count_all", 32'd5, 1'b1, 8);
        run_search("stop_first", 32'd5, 1'b0, 8);
        run_search("count_nine", 32'd9, 1'b1, 8);
    endtask

    task automatic test_clamp;
        for (int i = 0; i < 16; i++) write_entry(i, 32'd0);
        run_search("no_match16", 32'hDEADBEEF, 1'b0, 16);
        run_search("clamp31", 32'hDEADBEEF, 1'b1, 31);
        run_search("count_full", 32'd0, 1'b1, 31);
        run_search("len_zero", 32'd0, 1'b1, 0);
    endtask

    task automatic test_coincident_write;
        @(negedge clk1);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234_5678;
        start = 1'b1; key = 32'h1234_5678; mode = 1'b0; len = 5'd4;
        model_tbl[0] = 32'h1234_5678;
        finish_search("wr_with_start", 32'h1234_5678, 1'b0, 4, 1'b0);
        wr_en = 1'b0;
    endtask

    task automatic test_scan_ignore;
        for (int i = 0; i < 16; i++) write_entry(i, 32'(i + 100));
        @(negedge clk1);
        start = 1'b1; key = 32'hCAFE; mode = 1'b1; len = 5'd16;
        finish_search("ignore_in_scan", 32'hCAFE, 1'b1, 16, 1'b1);
        run_search("tbl5_unchanged", 32'd105, 1'b0, 16);
    endtask

    task automatic test_reset_mid_scan;
        int seen_done = 0;
        @(negedge clk1);
        start = 1'b1; key = 32'd999; mode = 1'b1; len = 5'd16;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (3) @(posedge clk1);
        #1; rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, found, match_idx, match_cnt} !== 12'd0) begin
            n_fail++; $display("FAIL mid_reset outputs: got %b want 0", {busy, done, found, match_idx, match_cnt});
        end
        for (int i = 0; i < 16; i++) model_tbl[i] = '0;
        repeat (2) @(posedge clk1);
        #1; rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk1); #1;
            if (done) seen_done++;
        end
        n_tests++;
        if (seen_done != 0) begin
            n_fail++; $display("FAIL mid_reset done_pulse: got %0d pulses want 0", seen_done);
        end
        run_search("post_reset_zero", 32'd0, 1'b1, 16);
        write_entry(0, 1); write_entry(1, 2); write_entry(2, 3);
        run_search("post_reset_basic", 32'd1, 1'b0, 3);
    endtask

    task automatic test_random;
        for (int t = 0; t < 20; t++) begin
            for (int j = 0; j < 3; j++) write_entry(int'($urandom_range(0, 15)), 32'($urandom_range(0, 3)));
            run_search("random", 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_back_to_back;
        // start held high across DONE relaunches on the following IDLE edge
        @(negedge clk1);
        start = 1'b1; key = 32'd77; mode = 1'b1; len = 5'd2;
        @(posedge clk1); #1;
        repeat (2) @(posedge clk1);
        #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL b2b first_done: got %b want 1", done);
        end
        @(posedge clk1); #1;
        finish_search("b2b_second", 32'd77, 1'b1, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_clamp();
        test_coincident_write();
        test_scan_ignore();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
